// File: rtl/oled_draw_arbiter.sv
// N-channel arbiter feeding one OLED character renderer: per-channel request FIFOs,
// round-robin or fixed-priority grant, one character in flight until drv_done or timeout.
module oled_draw_arbiter #(
  parameter int NUM_CH        = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 4096
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req_start,
  input  logic [8*NUM_CH-1:0]   req_ascii,
  input  logic [7*NUM_CH-1:0]   req_x,
  input  logic [4*NUM_CH-1:0]   req_y,
  output logic                  start_out,
  output logic [7:0]            ascii_out,
  output logic [6:0]            x_out,
  output logic [3:0]            y_out,
  output logic [2:0]            grant_ch,
  input  logic                  drv_done,
  output logic                  busy,
  output logic [NUM_CH-1:0]     pending,
  output logic [NUM_CH-1:0]     ovf,
  input  logic [NUM_CH-1:0]     ovf_clr,
  output logic                  timeout_err
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int EW  = 19;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [EW-1:0]     r_mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     r_rd_ptr [NUM_CH];
  logic [AW-1:0]     r_wr_ptr [NUM_CH];
  logic [CW-1:0]     r_cnt    [NUM_CH];
  logic [CW-1:0]     w_cnt_nxt[NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_drop;

  logic [CHW-1:0]    r_last;
  logic [CHW-1:0]    w_sel;
  logic [CHW-1:0]    w_pos;
  logic              w_sel_vld;
  int                w_idx;

  logic [TW-1:0]     r_tcnt;
  logic              w_issue;
  logic              w_tmo;
  logic [EW-1:0]     w_head;

  logic              r_start;
  logic              r_tmo;
  logic [7:0]        r_ascii;
  logic [6:0]        r_x;
  logic [3:0]        r_y;
  logic [2:0]        r_grant;

  // Channel select: scan from farthest to nearest candidate so the nearest non-empty one wins
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    w_idx     = 0;
    w_pos     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx     = (PRIORITY_MODE != 0) ? (k - 1) :
                  ((int'(r_last) + k >= NUM_CH) ? (int'(r_last) + k - NUM_CH) : (int'(r_last) + k));
      w_pos     = CHW'(w_idx);
      w_sel_vld = w_sel_vld | r_pending[w_pos];
      w_sel     = r_pending[w_pos] ? w_pos : w_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (drv_done) begin
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT > 0) && (r_tcnt == TW'(TIMEOUT))) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a write when its head leaves on the same edge
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    w_drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop[i]     = w_issue && (w_sel == CHW'(i));
      w_push[i]    = req_start[i] && ((r_cnt[i] < CW'(FIFO_DEPTH)) || w_pop[i]);
      w_drop[i]    = req_start[i] && !w_push[i];
      w_cnt_nxt[i] = r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
    end
  end

  assign w_head = r_mem[w_sel][r_rd_ptr[w_sel]];

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_pending <= '0;
      r_ovf     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        end
        r_cnt[i]     <= w_cnt_nxt[i];
        r_pending[i] <= (w_cnt_nxt[i] != '0);
        r_ovf[i]     <= (r_ovf[i] & ~ovf_clr[i]) | w_drop[i];
      end
    end
  end

  // Entry storage needs no reset: pointers and counts define what is valid
  always_ff @(posedge clk_50m) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i]] <= {req_ascii[8*i +: 8], req_x[7*i +: 7], req_y[4*i +: 4]};
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_start <= 1'b0;
      r_tmo   <= 1'b0;
      r_ascii <= 8'h00;
      r_x     <= 7'h00;
      r_y     <= 4'h0;
      r_grant <= 3'd0;
      r_last  <= CHW'(NUM_CH - 1);
      r_tcnt  <= '0;
    end else begin
      r_start <= w_issue;
      r_tmo   <= w_tmo;
      if (w_issue) begin
        {r_ascii, r_x, r_y} <= w_head;
        r_grant <= 3'(w_sel);
        r_last  <= w_sel;
        r_tcnt  <= '0;
      end else if (r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign start_out   = r_start;
  assign ascii_out   = r_ascii;
  assign x_out       = r_x;
  assign y_out       = r_y;
  assign grant_ch    = r_grant;
  assign busy        = (r_state == S_WAIT);
  assign pending     = r_pending;
  assign ovf         = r_ovf;
  assign timeout_err = r_tmo;

endmodule
